instr_load_mem: RTL and testbench
=================================

# instr_load_mem

Parametrised instruction memory with a streaming load port and a registered fetch port. It sits between the testbench/host loader and the fetch stage of the pipelined CPU. Words are written one per clock while `LoadInstructions` is high. After the load, the fetch stage reads by PC with one-cycle latency. Program contents and program length survive `Reset`, so a load, reset, run sequence executes the loaded program.

## Interface
Parameters:
- `DATA_W`, 32: instruction width in bits.
- `DEPTH`, 64: number of instruction words; must be ≥ 2.
- `PC_W`, 32: width of the `pc` input.
- `BYTE_ADDR`, 1: 1 means `pc` is a byte address (word index = `pc >> 2`, low 2 bits ignored); 0 means `pc` is a word index.
- `NOP`, 0: value returned for out-of-range or blocked fetches.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `LoadInstructions`, in, 1: load strobe; each high cycle writes one word.
- `Instruction`, in, DATA_W: word to write.
- `fetch_en`, in, 1: fetch request; 0 means stall (hold outputs).
- `pc`, in, PC_W: fetch address.
- `instr_out`, out, DATA_W: fetched instruction, registered.
- `instr_valid`, out, 1: `instr_out` corresponds to a completed fetch.
- `oob`, out, 1: the last fetch index was ≥ `prog_len`.
- `prog_len`, out, clog2(DEPTH)+1: number of words in the current program.
- `loading`, out, 1: high while in state LOAD.
- `load_done`, out, 1: one-cycle pulse on the first cycle after a load burst ends.
- `overflow`, out, 1: sticky; set when a write is attempted with the memory full.

## Operation
- The state machine has three states: IDLE, LOAD and RUN.
  - IDLE is entered on `Reset`.
  - From IDLE or RUN, `LoadInstructions`=1 moves to LOAD.
  - From LOAD, `LoadInstructions`=0 moves to RUN, and `load_done` pulses that cycle.
- Entering LOAD (first high cycle of a burst):
  - `wr_ptr` is set to 0 and `Instruction` is written to mem[0].
  - `prog_len` becomes 1 and `wr_ptr` becomes 1.
  - `overflow` is cleared.
- Each further high cycle in LOAD, with `wr_ptr` < DEPTH:
  - mem[`wr_ptr`] ← `Instruction`.
  - `wr_ptr` and `prog_len` each increment by 1.
- Full condition (`wr_ptr` == DEPTH with `LoadInstructions`=1): the write is dropped, `overflow` ← 1, and `prog_len` stays at DEPTH.
- Fetch in IDLE or RUN with `fetch_en`=1:
  - The index is computed from `pc` per `BYTE_ADDR`.
  - If the index < `prog_len`: `instr_out` ← mem[index], `oob` ← 0.
  - Otherwise (including any index ≥ DEPTH): `instr_out` ← `NOP`, `oob` ← 1.
  - `instr_valid` ← 1.
- `fetch_en`=0: `instr_out`, `instr_valid` and `oob` all hold their values.
- In LOAD, fetches are blocked: `instr_out` ← `NOP`, `instr_valid` ← 0, `oob` ← 0, regardless of `fetch_en`.
- `Reset` behaviour:
  - Cleared: state → IDLE, `wr_ptr` ← 0, `instr_out` ← `NOP`, `instr_valid` ← 0, `oob` ← 0, `load_done` ← 0, `overflow` ← 0.
  - Retained: memory contents and `prog_len`.
- Power-up: `prog_len` is 0 until the first load, so every fetch returns `NOP` with `oob`=1.

## Timing
- Reset values of outputs: `instr_out`=`NOP`, `instr_valid`=0, `oob`=0, `loading`=0, `load_done`=0, `overflow`=0; `prog_len` is unchanged by reset.
- Write latency: a word presented at edge N is readable by a fetch issued at edge N+1.
- Fetch latency: `pc`/`fetch_en` sampled at edge N gives `instr_out` valid after edge N; this is one-cycle latency, and back-to-back fetches give one word per clock.
- `loading` is a registered copy of state == LOAD. It rises the cycle after the first load edge and falls together with the `load_done` pulse.
- Simultaneous events:
  - `Reset` together with `LoadInstructions`: `Reset` wins and no write occurs.
  - `LoadInstructions` together with `fetch_en`: the load wins and the fetch is blocked.
- Reset in the middle of a burst: the words already written stay in memory and `prog_len` equals the count written. The next high cycle of `LoadInstructions` starts a new burst at index 0.
- A new burst after RUN fully replaces `prog_len`. Words beyond the new `prog_len` remain in memory but are unreachable (they read as `NOP` with `oob`=1).

## Test plan
- Load sequence: `Reset` 1 cycle, then 15 load cycles with words 0x00000000, 0x20010010, 0x20020018, …; then `Reset`. Fetch `pc`=0,4,8 → `instr_out` = 0x00000000, 0x20010010, 0x20020018 one cycle after each request; `prog_len`=15; `load_done` pulses exactly once.
- Out of range: after the 15-word load, fetch `pc`=60 → `NOP`, `instr_valid`=1, `oob`=1. Fetch `pc`=56 → word 14, `oob`=0. With `BYTE_ADDR`=1, `pc`=0x5 returns word 1.
- Overflow with `DEPTH`=4: 6 load cycles of words 0xA..0xF → `prog_len`=4, `overflow`=1 from the 5th load edge, and mem[0..3] = 0xA, 0xB, 0xC, 0xD.
- Stall and block: with `fetch_en`=0 for 3 cycles, `instr_out` holds its value. Asserting `LoadInstructions` with `fetch_en`=1 gives `instr_out`=`NOP` and `instr_valid`=0 on the next edge.
- Reset during a burst: load 5 words, assert `Reset` on the 3rd load edge → that write is dropped and `prog_len`=2; the next load edge writes index 0.
- Reload shorter program: load 10 words, then load 3 words → `prog_len`=3, and a fetch of index 5 returns `NOP` with `oob`=1.

Source files
------------

// File: rtl/instr_load_mem_if.sv
// Load/fetch bus between the host loader + fetch stage (master) and instr_load_mem (slave).
interface instr_load_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 64
) ();
    localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

    logic              LoadInstructions;
    logic [DATA_W-1:0] Instruction;
    logic              fetch_en;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              oob;
    logic [LEN_W-1:0]  prog_len;
    logic              loading;
    logic              load_done;
    logic              overflow;

    modport master (
        output LoadInstructions, Instruction, fetch_en, pc,
        input  instr_out, instr_valid, oob, prog_len, loading, load_done, overflow
    );

    modport slave (
        input  LoadInstructions, Instruction, fetch_en, pc,
        output instr_out, instr_valid, oob, prog_len, loading, load_done, overflow
    );
endinterface

// File: rtl/instr_load_mem.sv
// Instruction memory: streaming burst loader plus one-cycle registered fetch port.
// Memory contents and program length are deliberately kept across Reset.
module instr_load_mem #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       PC_W      = 32,
    parameter int unsigned       BYTE_ADDR = 1,
    parameter logic [DATA_W-1:0] NOP       = '0
) (
    input  logic           clk,
    input  logic           Reset,
    instr_load_mem_if.slave bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LEN_W = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  prog_len_q, prog_len_d;
    logic              overflow_q, overflow_d;
    logic              load_done_q, load_done_d;
    logic              loading_q, loading_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic              oob_q, oob_d;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [PC_W-1:0]   fetch_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, load bookkeeping and fetch result
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        prog_len_d    = prog_len_q;
        overflow_d    = overflow_q;
        load_done_d   = 1'b0;
        instr_out_d   = instr_out_q;
        instr_valid_d = instr_valid_q;
        oob_d         = oob_q;
        mem_we        = 1'b0;
        mem_waddr     = AW'(0);
        fetch_idx     = (BYTE_ADDR != 0) ? (bus.pc >> 2) : bus.pc;

        case (state_q)
            IDLE, RUN: begin
                if (bus.LoadInstructions) begin
                    state_d    = LOAD;
                    mem_we     = 1'b1;
                    mem_waddr  = AW'(0);
                    wr_ptr_d   = LEN_W'(1);
                    prog_len_d = LEN_W'(1);
                    overflow_d = 1'b0;
                end
            end
            LOAD: begin
                if (bus.LoadInstructions) begin
                    if (wr_ptr_q < LEN_W'(DEPTH)) begin
                        mem_we     = 1'b1;
                        mem_waddr  = wr_ptr_q[AW-1:0];
                        wr_ptr_d   = wr_ptr_q + LEN_W'(1);
                        prog_len_d = prog_len_q + LEN_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset beats a simultaneous load: no write, program length untouched
        if (Reset) begin
            mem_we     = 1'b0;
            prog_len_d = prog_len_q;
        end

        loading_d = (state_d == LOAD);

        if ((state_q == LOAD) || bus.LoadInstructions) begin
            instr_out_d   = NOP;
            instr_valid_d = 1'b0;
            oob_d         = 1'b0;
        end else if (bus.fetch_en) begin
            instr_valid_d = 1'b1;
            if (fetch_idx < PC_W'(prog_len_q)) begin
                instr_out_d = mem[fetch_idx[AW-1:0]];
                oob_d       = 1'b0;
            end else begin
                instr_out_d = NOP;
                oob_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= LEN_W'(0);
            overflow_q    <= 1'b0;
            load_done_q   <= 1'b0;
            loading_q     <= 1'b0;
            instr_out_q   <= NOP;
            instr_valid_q <= 1'b0;
            oob_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            overflow_q    <= overflow_d;
            load_done_q   <= load_done_d;
            loading_q     <= loading_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            oob_q         <= oob_d;
        end
    end

    // Unreset storage: survives Reset by design
    always_ff @(posedge clk) begin
        prog_len_q <= prog_len_d;
        if (mem_we) begin
            mem[mem_waddr] <= bus.Instruction;
        end
    end

    assign bus.instr_out   = instr_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.oob         = oob_q;
    assign bus.prog_len    = prog_len_q;
    assign bus.loading     = loading_q;
    assign bus.load_done   = load_done_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_instr_load_mem.sv
// Directed + random bench for instr_load_mem: a 64-word byte-addressed instance and a
// 4-word word-addressed instance, checked against a burst-level memory model.
module tb_instr_load_mem;
    localparam logic [31:0] NOP_A = 32'h0000_0013;
    localparam int          DEP_A = 64;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    instr_load_mem_if #(.DATA_W(32), .PC_W(32), .DEPTH(64)) ifa ();
    instr_load_mem_if #(.DATA_W(32), .PC_W(32), .DEPTH(4))  ifb ();

    instr_load_mem #(.DATA_W(32), .DEPTH(64), .PC_W(32), .BYTE_ADDR(1), .NOP(NOP_A))
        dut_a (.clk(clk), .Reset(rst_a), .bus(ifa));
    instr_load_mem #(.DATA_W(32), .DEPTH(4), .PC_W(32), .BYTE_ADDR(0), .NOP(32'h0))
        dut_b (.clk(clk), .Reset(rst_b), .bus(ifb));

    int errors = 0;
    int checks = 0;
    int pulses_a = 0;

    // Reference model of instance A: burst-level view of the program
    logic [31:0] mem_a [DEP_A];
    int          len_a = 0;
    int          cnt_a = 0;
    bit          in_burst_a = 0;

    always @(negedge clk) if (ifa.load_done === 1'b1) pulses_a++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int i);
        return (i == 0) ? 32'h0 : (32'h2000_0000 | (32'(i) << 16) | 32'(8 + 8 * i));
    endfunction

    task automatic load_word_a(input logic [31:0] w);
        ifa.LoadInstructions = 1'b1;
        ifa.Instruction      = w;
        step();
        if (!in_burst_a) begin
            in_burst_a = 1;
            cnt_a      = 0;
        end
        if (cnt_a < DEP_A) begin
            mem_a[cnt_a] = w;
            cnt_a++;
        end
        len_a = cnt_a;
    endtask

    task automatic end_burst_a();
        ifa.LoadInstructions = 1'b0;
        step();
        in_burst_a = 0;
    endtask

    task automatic fetch_a(input int unsigned pc);
        int unsigned idx;
        idx          = pc >> 2;
        ifa.fetch_en = 1'b1;
        ifa.pc       = pc;
        step();
        chk("a_instr", ifa.instr_out, (idx < 32'(len_a)) ? mem_a[idx] : NOP_A);
        chk("a_valid", 32'(ifa.instr_valid), 32'(1));
        chk("a_oob", 32'(ifa.oob), (idx < 32'(len_a)) ? 32'(0) : 32'(1));
        ifa.fetch_en = 1'b0;
    endtask

    task automatic fetch_b(input int unsigned pc, input logic [31:0] exp, input int exp_oob);
        ifb.fetch_en = 1'b1;
        ifb.pc       = pc;
        step();
        chk("b_instr", ifb.instr_out, exp);
        chk("b_valid", 32'(ifb.instr_valid), 32'(1));
        chk("b_oob", 32'(ifb.oob), 32'(exp_oob));
        ifb.fetch_en = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int          lim;

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.LoadInstructions = 1'b0; ifa.Instruction = '0; ifa.fetch_en = 1'b0; ifa.pc = '0;
        ifb.LoadInstructions = 1'b0; ifb.Instruction = '0; ifb.fetch_en = 1'b0; ifb.pc = '0;
        step();
        chk("rst_instr", ifa.instr_out, NOP_A);
        chk("rst_valid", 32'(ifa.instr_valid), 32'(0));
        chk("rst_oob", 32'(ifa.oob), 32'(0));
        chk("rst_loading", 32'(ifa.loading), 32'(0));
        chk("rst_load_done", 32'(ifa.load_done), 32'(0));
        chk("rst_overflow", 32'(ifa.overflow), 32'(0));
        chk("rst_b_instr", ifb.instr_out, 32'h0);
        chk("rst_b_overflow", 32'(ifb.overflow), 32'(0));
        rst_a = 1'b0; rst_b = 1'b0;

        // 15-word program, then reset, then run
        for (int i = 0; i < 15; i++) begin
            load_word_a(word_of(i));
            if (i == 0) chk("loading_rise", 32'(ifa.loading), 32'(1));
        end
        end_burst_a();
        chk("load_done_pulse", 32'(ifa.load_done), 32'(1));
        chk("loading_fall", 32'(ifa.loading), 32'(0));
        chk("prog_len_15", 32'(ifa.prog_len), 32'(15));
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("prog_len_kept", 32'(ifa.prog_len), 32'(15));
        chk("load_done_cleared", 32'(ifa.load_done), 32'(0));
        chk("load_done_once", 32'(pulses_a), 32'(1));

        fetch_a(0); fetch_a(4); fetch_a(8);
        fetch_a(60); fetch_a(56); fetch_a(5);
        for (int k = 0; k < 8; k++) fetch_a($urandom_range(0, 300));

        // Stall holds outputs
        fetch_a(8);
        for (int k = 0; k < 3; k++) begin
            ifa.pc = $urandom;
            step();
            chk("stall_instr", ifa.instr_out, word_of(2));
            chk("stall_valid", 32'(ifa.instr_valid), 32'(1));
        end
        fetch_a(60);
        step();
        chk("stall_oob", 32'(ifa.oob), 32'(1));

        // Load blocks a simultaneous fetch; 10-word program then a 3-word reload
        ifa.fetch_en = 1'b1;
        ifa.pc       = 4;
        load_word_a($urandom);
        chk("block_instr", ifa.instr_out, NOP_A);
        chk("block_valid", 32'(ifa.instr_valid), 32'(0));
        chk("block_oob", 32'(ifa.oob), 32'(0));
        for (int i = 1; i < 10; i++) load_word_a($urandom);
        end_burst_a();
        ifa.fetch_en = 1'b0;
        chk("prog_len_10", 32'(ifa.prog_len), 32'(10));
        fetch_a(36);
        for (int i = 0; i < 3; i++) load_word_a($urandom);
        end_burst_a();
        chk("prog_len_3", 32'(ifa.prog_len), 32'(3));
        fetch_a(20); fetch_a(8); fetch_a(16); fetch_a(0);

        // Reset on the 3rd edge of a burst drops that write; next edge restarts at 0
        load_word_a($urandom);
        load_word_a($urandom);
        rst_a = 1'b1;
        ifa.Instruction = $urandom;
        step();
        in_burst_a = 0;
        rst_a = 1'b0;
        chk("midrst_prog_len", 32'(ifa.prog_len), 32'(2));
        chk("midrst_loading", 32'(ifa.loading), 32'(0));
        w = $urandom;
        load_word_a(w);
        chk("restart_prog_len", 32'(ifa.prog_len), 32'(1));
        end_burst_a();
        fetch_a(0); fetch_a(4);
        chk("restart_word0", mem_a[0], w);

        // Overflow on the 4-word instance
        for (int k = 1; k <= 6; k++) begin
            ifb.LoadInstructions = 1'b1;
            ifb.Instruction      = 32'hA + 32'(k - 1);
            step();
            lim = (k < 4) ? k : 4;
            chk("b_overflow", 32'(ifb.overflow), (k >= 5) ? 32'(1) : 32'(0));
            chk("b_prog_len", 32'(ifb.prog_len), 32'(lim));
        end
        ifb.LoadInstructions = 1'b0;
        step();
        chk("b_load_done", 32'(ifb.load_done), 32'(1));
        chk("b_overflow_sticky", 32'(ifb.overflow), 32'(1));
        for (int i = 0; i < 4; i++) fetch_b(i, 32'hA + 32'(i), 0);
        fetch_b(4, 32'h0, 1);
        ifb.LoadInstructions = 1'b1;
        ifb.Instruction      = 32'h55;
        step();
        chk("b_overflow_clear", 32'(ifb.overflow), 32'(0));
        chk("b_prog_len_1", 32'(ifb.prog_len), 32'(1));
        ifb.LoadInstructions = 1'b0;
        step();
        fetch_b(0, 32'h55, 0);
        fetch_b(1, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
